// File: rtl/sc_score_pkg.sv
// ----------------------------------------------------------------------------
// sc_score_pkg
// Shared definitions for the BCD score counter slice.
//   BCD_DIGIT_W  width of one BCD digit
//   BCD_MAX      largest legal digit value
//   bcd_digit_t  one BCD digit
//   clamp_step() limits a raw step value to a single BCD digit (0..9)
// ----------------------------------------------------------------------------
package sc_score_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Any step above 9 cannot be a single BCD digit, so it is treated as 9.
    function automatic bcd_digit_t clamp_step(input logic [31:0] step);
        if (step > 32'(BCD_MAX)) begin
            return BCD_MAX;
        end
        return step[BCD_DIGIT_W-1:0];
    endfunction

endpackage

// File: rtl/sc_scorecounter_if.sv
// ----------------------------------------------------------------------------
// sc_scorecounter_if
// Request/score bundle of the BCD score counter.
//   SC_SCORECOUNTER_clear_InHigh     clear score and flags
//   SC_SCORECOUNTER_upcount_InLow    add request, active low, edge-counted
//   SC_SCORECOUNTER_downcount_InLow  subtract request, active low, edge-counted
//   SC_SCORECOUNTER_step_InBUS       BCD amount per event
//   SC_SCORECOUNTER_data_OutBUS      BCD score, digit 0 in bits [3:0]
//   SC_SCORECOUNTER_overflow_Out     sticky overflow
//   SC_SCORECOUNTER_underflow_Out    sticky underflow
//   SC_SCORECOUNTER_highscore_OutBUS best score seen (only with
//                                    SC_SCORECOUNTER_HIGHSCORE_EN defined)
// Modports: master drives the requests, slave is the counter.
// ----------------------------------------------------------------------------
interface sc_scorecounter_if #(
    parameter int NUM_DIGITS = 3,
    parameter int STEP_WIDTH = 4
);
    import sc_score_pkg::*;

    logic                      SC_SCORECOUNTER_clear_InHigh;
    logic                      SC_SCORECOUNTER_upcount_InLow;
    logic                      SC_SCORECOUNTER_downcount_InLow;
    logic [STEP_WIDTH-1:0]     SC_SCORECOUNTER_step_InBUS;
    logic [4*NUM_DIGITS-1:0]   SC_SCORECOUNTER_data_OutBUS;
    logic                      SC_SCORECOUNTER_overflow_Out;
    logic                      SC_SCORECOUNTER_underflow_Out;
`ifdef SC_SCORECOUNTER_HIGHSCORE_EN
    logic [4*NUM_DIGITS-1:0]   SC_SCORECOUNTER_highscore_OutBUS;
`endif

    modport master (
        output SC_SCORECOUNTER_clear_InHigh,
        output SC_SCORECOUNTER_upcount_InLow,
        output SC_SCORECOUNTER_downcount_InLow,
        output SC_SCORECOUNTER_step_InBUS,
        input  SC_SCORECOUNTER_data_OutBUS,
        input  SC_SCORECOUNTER_overflow_Out,
        input  SC_SCORECOUNTER_underflow_Out
`ifdef SC_SCORECOUNTER_HIGHSCORE_EN
        , input SC_SCORECOUNTER_highscore_OutBUS
`endif
    );

    modport slave (
        input  SC_SCORECOUNTER_clear_InHigh,
        input  SC_SCORECOUNTER_upcount_InLow,
        input  SC_SCORECOUNTER_downcount_InLow,
        input  SC_SCORECOUNTER_step_InBUS,
        output SC_SCORECOUNTER_data_OutBUS,
        output SC_SCORECOUNTER_overflow_Out,
        output SC_SCORECOUNTER_underflow_Out
`ifdef SC_SCORECOUNTER_HIGHSCORE_EN
        , output SC_SCORECOUNTER_highscore_OutBUS
`endif
    );

endinterface

// File: rtl/sc_bcddigit.sv
// ----------------------------------------------------------------------------
// sc_bcddigit
// Next-value logic for one registered BCD digit of the score.
//   digit_in   current digit (0..9)
//   operand    value added/subtracted at this digit (0..9)
//   cy_in      carry (add) or borrow (subtract) from the digit below
//   sub        1: subtract, 0: add
//   digit_nxt  corrected result digit, always 0..9
//   cy_out     carry/borrow into the digit above
// ----------------------------------------------------------------------------
module sc_bcddigit
    import sc_score_pkg::*;
(
    input  bcd_digit_t digit_in,
    input  bcd_digit_t operand,
    input  logic       cy_in,
    input  logic       sub,
    output bcd_digit_t digit_nxt,
    output logic       cy_out
);

    logic        [4:0] sum;
    logic signed [5:0] diff;
    logic              sum_cy;
    logic              diff_bw;

    always_comb begin
        sum     = {1'b0, digit_in} + {1'b0, operand} + {4'b0000, cy_in};
        diff    = $signed({2'b00, digit_in}) - $signed({2'b00, operand})
                - $signed({5'b00000, cy_in});
        // Decimal correction: above 9 wraps by -10, below 0 wraps by +10.
        sum_cy  = (sum > 5'd9);
        diff_bw = diff[5];
        digit_nxt = digit_in;
        cy_out    = 1'b0;
        if (sub) begin
            digit_nxt = diff_bw ? bcd_digit_t'(diff + 6'sd10) : diff[3:0];
            cy_out    = diff_bw;
        end else begin
            digit_nxt = sum_cy ? bcd_digit_t'(sum - 5'd10) : sum[3:0];
            cy_out    = sum_cy;
        end
    end

endmodule

// File: rtl/sc_scorecounter.sv
// ----------------------------------------------------------------------------
// sc_scorecounter
// BCD score counter: one add/subtract of a BCD step per falling edge of the
// active-low requests, saturating (WRAP_MODE=0) or wrapping (WRAP_MODE=1) at
// the decimal limit, with sticky over/underflow flags.
//   SC_SCORECOUNTER_CLOCK_50      system clock
//   SC_SCORECOUNTER_RESET_InHigh  synchronous active-high reset
//   bus                           sc_scorecounter_if.slave (requests, score, flags)
// Optional macro SC_SCORECOUNTER_HIGHSCORE_EN adds the highscore output.
// ----------------------------------------------------------------------------
module sc_scorecounter
    import sc_score_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int WRAP_MODE  = 0,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  SC_SCORECOUNTER_CLOCK_50,
    input  logic                  SC_SCORECOUNTER_RESET_InHigh,
    sc_scorecounter_if.slave      bus
);

    localparam int DATA_W = BCD_DIGIT_W * NUM_DIGITS;
    localparam logic [DATA_W-1:0] ALL_NINES = {NUM_DIGITS{BCD_MAX}};

    logic [DATA_W-1:0]   score_q;
    logic [DATA_W-1:0]   score_d;
    logic [DATA_W-1:0]   arith;
    logic [NUM_DIGITS:0] cy;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                up_hist_q, dn_hist_q;
    logic                armed_q;
    bcd_digit_t          step_c;
    logic                up_ev, dn_ev, do_add, do_sub;

    // The history registers come out of reset at 1, which on its own would
    // count a request held low through reset on the first edge after it.
    // armed_q masks that single edge; by the next edge the history already
    // holds the low level, so a held request never counts.
    assign step_c = clamp_step(32'(bus.SC_SCORECOUNTER_step_InBUS));
    assign up_ev  = armed_q & up_hist_q & ~bus.SC_SCORECOUNTER_upcount_InLow;
    assign dn_ev  = armed_q & dn_hist_q & ~bus.SC_SCORECOUNTER_downcount_InLow;
    assign do_add = up_ev & ~dn_ev & (step_c != '0);
    assign do_sub = dn_ev & ~up_ev & (step_c != '0);
    assign cy[0]  = 1'b0;

    // Ripple carry/borrow chain; only digit 0 sees the step.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        sc_bcddigit u_digit (
            .digit_in  (score_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .operand   ((g == 0) ? step_c : bcd_digit_t'(0)),
            .cy_in     (cy[g]),
            .sub       (do_sub),
            .digit_nxt (arith[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cy_out    (cy[g+1])
        );
    end

    always_comb begin
        score_d = score_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (bus.SC_SCORECOUNTER_clear_InHigh) begin
            score_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (do_add) begin
            score_d = arith;
            if (cy[NUM_DIGITS]) begin
                ovf_d = 1'b1;
                if (WRAP_MODE == 0) score_d = ALL_NINES;
            end
        end else if (do_sub) begin
            score_d = arith;
            if (cy[NUM_DIGITS]) begin
                unf_d = 1'b1;
                if (WRAP_MODE == 0) score_d = '0;
            end
        end
    end

    always_ff @(posedge SC_SCORECOUNTER_CLOCK_50) begin
        if (SC_SCORECOUNTER_RESET_InHigh) begin
            score_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            up_hist_q <= 1'b1;
            dn_hist_q <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            score_q   <= score_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            up_hist_q <= bus.SC_SCORECOUNTER_upcount_InLow;
            dn_hist_q <= bus.SC_SCORECOUNTER_downcount_InLow;
            armed_q   <= 1'b1;
        end
    end

    assign bus.SC_SCORECOUNTER_data_OutBUS   = score_q;
    assign bus.SC_SCORECOUNTER_overflow_Out  = ovf_q;
    assign bus.SC_SCORECOUNTER_underflow_Out = unf_q;

`ifdef SC_SCORECOUNTER_HIGHSCORE_EN
    // BCD digits order like binary, so a plain magnitude compare suffices.
    logic [DATA_W-1:0] hs_q;

    always_ff @(posedge SC_SCORECOUNTER_CLOCK_50) begin
        if (SC_SCORECOUNTER_RESET_InHigh) begin
            hs_q <= '0;
        end else if (score_d > hs_q) begin
            hs_q <= score_d;
        end
    end

    assign bus.SC_SCORECOUNTER_highscore_OutBUS = hs_q;
`endif

endmodule
